// File: rtl/program_mem.sv
// program_mem: loadable program memory for the CPU fetch path.
//
// A byte-stream loader fills the array through a valid/ready handshake.
// The CPU then reads it through a request port with a registered result
// one cycle later. A three-state FSM (IDLE -> LOAD -> RUN) blocks fetches
// until a load has completed. It also keeps load and fetch mutually
// exclusive, so a read and a write never hit the array in the same cycle.
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   load_start    pulse that starts a new load at word 0 (ignored while loading)
//   load_valid    load_data/load_last are valid this cycle
//   load_data     word to write
//   load_last     marks the final word of the load
//   load_ready    the loader may transfer this cycle (high only in LOAD)
//   load_done     one-cycle pulse after the transfer that completed the load
//   load_ovf      sticky: the load filled DEPTH words without load_last
//   load_count    number of words written by the current or most recent load
//   fetch_req     fetch request
//   fetch_addr    fetch address
//   fetch_ready   a fetch_req is accepted this cycle (high only in RUN)
//   fetch_valid   fetch_data/fetch_err hold the result of last cycle's accept
//   fetch_data    fetched word (0 for an out-of-range address); held otherwise
//   fetch_err     the accepted address was >= DEPTH
module program_mem #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_ovf,
  output logic [CNT_W-1:0]  load_count,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              xfer;
  logic              ptr_at_end;
  logic              load_end;
  logic              start_load;
  logic              fetch_acc_p0;
  logic              in_range_p0;
  logic [IDX_W-1:0]  rd_idx_p0;

  logic              fetch_vld_p1;
  logic [DATA_W-1:0] fetch_data_p1;
  logic              fetch_err_p1;

  // The handshake terms are decoded from the registered state, not from
  // load_ready or fetch_ready. This keeps them out of the FSM's combinational
  // loop.
  assign xfer         = load_valid && (state_q == LOAD);
  assign ptr_at_end   = (wr_ptr == IDX_W'(DEPTH - 1));
  assign load_end     = xfer && (load_last || ptr_at_end);
  assign start_load   = load_start && (state_q != LOAD);
  assign fetch_acc_p0 = fetch_req && (state_q == RUN);

  // An address is in range when no bit above the index field is set.
  // When DEPTH == 2**ADDR_W the shift clears every bit, so every address
  // counts as in range.
  assign in_range_p0  = ((fetch_addr >> IDX_W) == '0);
  assign rd_idx_p0    = fetch_addr[IDX_W-1:0];

  always_comb begin
    state_d     = state_q;
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_end) state_d = RUN;
      end
      RUN: begin
        fetch_ready = 1'b1;
        if (load_start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      load_count <= '0;
      load_ovf   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_done <= load_end;
      if (start_load) begin
        wr_ptr     <= '0;
        load_count <= '0;
        load_ovf   <= 1'b0;
      end else if (xfer) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (load_count != CNT_W'(DEPTH)) load_count <= load_count + 1'b1;
        // Filling the last word without load_last means the stream was
        // longer than the array.
        if (!load_last && ptr_at_end) load_ovf <= 1'b1;
      end
    end
  end

  // The array has no reset. Its contents after reset are whatever the
  // last (possibly partial) load left behind.
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr] <= load_data;
  end

  // ---- stage p0 -> p1: registered fetch result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_vld_p1  <= 1'b0;
      fetch_data_p1 <= '0;
      fetch_err_p1  <= 1'b0;
    end else begin
      fetch_vld_p1 <= fetch_acc_p0;
      if (fetch_acc_p0) begin
        fetch_data_p1 <= in_range_p0 ? mem[rd_idx_p0] : '0;
        fetch_err_p1  <= !in_range_p0;
      end
    end
  end

  assign fetch_valid = fetch_vld_p1;
  assign fetch_data  = fetch_data_p1;
  assign fetch_err   = fetch_err_p1;

endmodule

// File: tb/tb_program_mem.sv
module tb_program_mem;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int CW    = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;
  logic          load_ovf;
  logic [CW-1:0] load_count;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the array should hold, and the value that
  // fetch_data should be showing.
  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_fdata;

  program_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_ovf(load_ovf), .load_count(load_count),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load_start = 0; load_valid = 0; load_data = '0; load_last = 0;
    fetch_req = 0; fetch_addr = '0;
    repeat (2) tick;
    n_checks++;
    if ({load_ready, load_done, load_ovf, load_count, fetch_ready, fetch_valid, fetch_data, fetch_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b done=%b ovf=%b cnt=%0d frdy=%b fvld=%b fdata=%h ferr=%b, expected all 0",
               load_ready, load_done, load_ovf, load_count, fetch_ready, fetch_valid, fetch_data, fetch_err);
    end
    rst_n = 1'b1;
    model_fdata = 8'h00;
    tick;
  endtask

  task automatic test_idle_fetch;
    for (int k = 0; k < 5; k++) begin
      fetch_req = 1'b1; fetch_addr = AW'(k);
      n_checks++;
      if (fetch_ready !== 1'b0) begin
        n_fail++; $display("FAIL idle_fetch_ready: got %b expected 0 (cycle %0d)", fetch_ready, k);
      end
      tick;
      n_checks++;
      if (fetch_valid !== 1'b0) begin
        n_fail++; $display("FAIL idle_fetch_valid: got %b expected 0 (cycle %0d)", fetch_valid, k);
      end
    end
    fetch_req = 1'b0;
  endtask

  // Streams words into the DUT with random idle gaps. With use_last the
  // final word carries load_last. Without it the stream must be at least
  // DEPTH long, and every word past DEPTH must be refused.
  task automatic do_load(input string name, input logic [7:0] words[$], input bit use_last);
    int n;
    int end_idx;
    int i;
    bit exp_rdy;
    n = words.size();
    end_idx = use_last ? n - 1 : DEPTH - 1;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    n_checks++;
    if ({load_ready, fetch_ready, load_ovf, load_count} !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL %s_entry: got rdy=%b frdy=%b ovf=%b cnt=%0d expected rdy=1 frdy=0 ovf=0 cnt=0",
               name, load_ready, fetch_ready, load_ovf, load_count);
    end
    i = 0;
    while (i < n) begin
      if (i <= end_idx && $urandom_range(0, 3) == 0) begin
        load_valid = 1'b0; load_last = 1'b0;
        tick;
        n_checks++;
        if (load_done !== 1'b0) begin
          n_fail++; $display("FAIL %s_done_gap: got %b expected 0 at word %0d", name, load_done, i);
        end
        continue;
      end
      load_valid = 1'b1; load_data = words[i];
      load_last = use_last && (i == n - 1);
      exp_rdy = (i <= end_idx);
      n_checks++;
      if (load_ready !== exp_rdy) begin
        n_fail++; $display("FAIL %s_ready: got %b expected %b at word %0d", name, load_ready, exp_rdy, i);
      end
      if (exp_rdy) model_mem[i] = words[i];
      tick;
      n_checks++;
      if (load_done !== (i == end_idx)) begin
        n_fail++; $display("FAIL %s_done: got %b expected %b after word %0d", name, load_done, (i == end_idx), i);
      end
      i++;
    end
    load_valid = 1'b0; load_last = 1'b0;
    tick;
    n_checks++;
    if ({load_done, load_ready, fetch_ready, load_ovf, load_count} !==
        {1'b0, 1'b0, 1'b1, !use_last, CW'(end_idx + 1)}) begin
      n_fail++;
      $display("FAIL %s_final: got done=%b rdy=%b frdy=%b ovf=%b cnt=%0d expected done=0 rdy=0 frdy=1 ovf=%b cnt=%0d",
               name, load_done, load_ready, fetch_ready, load_ovf, load_count, !use_last, end_idx + 1);
    end
  endtask

  // Issues fetches (optionally with random idle cycles). Each result must
  // appear exactly one cycle after its request.
  task automatic run_fetch(input string name, input logic [15:0] addrs[$], input bit gaps);
    int idx;
    bit acc;
    logic [7:0] exp_d;
    logic exp_e;
    idx = 0;
    while (idx < addrs.size()) begin
      acc = 1'b0;
      exp_d = 8'h00;
      exp_e = 1'b0;
      if (!(gaps && $urandom_range(0, 2) == 0)) begin
        fetch_req = 1'b1; fetch_addr = addrs[idx];
        exp_e = (addrs[idx] >= DEPTH);
        exp_d = exp_e ? 8'h00 : model_mem[addrs[idx] % DEPTH];
        acc = 1'b1;
        idx++;
      end else begin
        fetch_req = 1'b0;
      end
      n_checks++;
      if (fetch_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s_fetch_ready: got %b expected 1", name, fetch_ready);
      end
      tick;
      if (acc) model_fdata = exp_d;
      n_checks++;
      if (fetch_valid !== acc || fetch_data !== model_fdata || (acc && fetch_err !== exp_e)) begin
        n_fail++;
        $display("FAIL %s_result: got vld=%b data=%h err=%b expected vld=%b data=%h err=%b (addr %h)",
                 name, fetch_valid, fetch_data, fetch_err, acc, model_fdata, exp_e, fetch_addr);
      end
    end
    fetch_req = 1'b0;
    tick;
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== model_fdata) begin
      n_fail++;
      $display("FAIL %s_hold: got vld=%b data=%h expected vld=0 data=%h", name, fetch_valid, fetch_data, model_fdata);
    end
  endtask

  task automatic test_load_basic;
    logic [7:0] q[$];
    q = {8'hA9, 8'h00, 8'h01, 8'h01, 8'h4C, 8'h02, 8'h00};
    do_load("basic", q, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [15:0] a[$];
    logic [7:0] exp_prog[$];
    a = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    run_fetch("b2b", a, 1'b0);
    // Independent check against the literal program bytes.
    exp_prog = {8'hA9, 8'h00, 8'h01, 8'h01, 8'h4C, 8'h02, 8'h00};
    n_checks++;
    if (model_mem[4] !== exp_prog[4] || fetch_data !== exp_prog[6]) begin
      n_fail++; $display("FAIL b2b_program: got last=%h expected %h", fetch_data, exp_prog[6]);
    end
  endtask

  task automatic test_out_of_range;
    logic [15:0] a[$];
    a = {16'h0100, 16'h0004};
    run_fetch("oor", a, 1'b0);
  endtask

  task automatic test_fetch_with_load_start;
    logic [7:0] exp_d;
    exp_d = model_mem[2];
    fetch_req = 1'b1; fetch_addr = 16'd2; load_start = 1'b1;
    tick;
    fetch_req = 1'b0; load_start = 1'b0;
    model_fdata = exp_d;
    n_checks++;
    if ({fetch_valid, fetch_data, fetch_err, load_ready, fetch_ready, load_count} !==
        {1'b1, 8'h01, 1'b0, 1'b1, 1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL concurrent: got vld=%b data=%h err=%b rdy=%b frdy=%b cnt=%0d expected vld=1 data=01 err=0 rdy=1 frdy=0 cnt=0",
               fetch_valid, fetch_data, fetch_err, load_ready, fetch_ready, load_count);
    end
    tick;
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== model_fdata || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL concurrent_after: got vld=%b data=%h rdy=%b expected vld=0 data=%h rdy=1",
               fetch_valid, fetch_data, load_ready, model_fdata);
    end
  endtask

  task automatic test_full_load_random;
    logic [7:0] q[$];
    logic [15:0] a[$];
    for (int k = 0; k < DEPTH; k++) q.push_back(8'($urandom));
    // load_last on word DEPTH-1 is a normal completion, not an overflow.
    do_load("full", q, 1'b1);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) a.push_back(16'($urandom));
      else a.push_back(16'($urandom_range(0, DEPTH - 1)));
    end
    a.push_back(16'd255);
    a.push_back(16'd256);
    a.push_back(16'hFFFF);
    run_fetch("rand", a, 1'b1);
  endtask

  task automatic test_overflow;
    logic [7:0] q[$];
    logic [15:0] a[$];
    for (int k = 0; k < DEPTH + 4; k++) q.push_back(8'(k) ^ 8'h5A);
    do_load("ovf", q, 1'b0);
    // Word 0 must not have been overwritten by the refused words 256..259.
    a = {16'd0, 16'd255, 16'd128};
    run_fetch("ovf_fetch", a, 1'b0);
    n_checks++;
    if (model_mem[0] !== 8'h5A) begin
      n_fail++; $display("FAIL ovf_model: got %h expected 5a", model_mem[0]);
    end
  endtask

  task automatic test_reset_during_load;
    logic [7:0] q[$];
    logic [15:0] a[$];
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      load_valid = 1'b1; load_data = 8'hC0 + 8'(j);
      tick;
    end
    n_checks++;
    if (load_count !== CW'(3)) begin
      n_fail++; $display("FAIL rst_pre_count: got %0d expected 3", load_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_fdata = 8'h00;
    n_checks++;
    if ({load_ready, load_done, load_ovf, load_count, fetch_ready, fetch_valid, fetch_data, fetch_err} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_load: got rdy=%b done=%b ovf=%b cnt=%0d frdy=%b fvld=%b fdata=%h ferr=%b, expected all 0",
               load_ready, load_done, load_ovf, load_count, fetch_ready, fetch_valid, fetch_data, fetch_err);
    end
    load_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      load_valid = 1'b1;
      tick;
      n_checks++;
      if (load_ready !== 1'b0 || fetch_ready !== 1'b0) begin
        n_fail++; $display("FAIL rst_idle: got rdy=%b frdy=%b expected 0 0", load_ready, fetch_ready);
      end
    end
    load_valid = 1'b0;
    q = {8'h3C, 8'hD5};
    do_load("reload", q, 1'b1);
    a = {16'd1, 16'd0};
    run_fetch("reload_fetch", a, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_fetch();
    test_load_basic();
    test_back_to_back();
    test_out_of_range();
    test_fetch_with_load_start();
    test_full_load_random();
    test_overflow();
    test_reset_during_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_mem.md
Name: program_mem

Overview:
Parametrised, loadable program memory that replaces the fixed combinational program ROM. A byte-stream loader port with a valid/ready handshake fills the array. The CPU then fetches through a registered request/valid port with 1-cycle latency. A small FSM gates fetches until a load completes and flags out-of-range fetches and load overflow.

Parameters:
ADDR_W, 16, fetch address width in bits
DATA_W, 8, memory word width in bits
DEPTH, 256, number of words; power of 2, 2 <= DEPTH <= 2**ADDR_W
CNT_W, $clog2(DEPTH)+1, width of load_count

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse; begins a new load at word 0
load_valid  in  1  load_data is valid this cycle
load_data  in  DATA_W  program word to write
load_last  in  1  qualifies the final word of the load (sampled with load_valid)
load_ready  out  1  loader may transfer this cycle
load_done  out  1  one-cycle pulse when a load completes
load_ovf  out  1  sticky; load stopped at DEPTH without load_last
load_count  out  CNT_W  words written by the current or last load
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  fetch address
fetch_ready  out  1  fetch_req is accepted this cycle
fetch_valid  out  1  fetch_data/fetch_err are valid
fetch_data  out  DATA_W  fetched word
fetch_err  out  1  accepted address was >= DEPTH

Behaviour:
- FSM states: IDLE, LOAD, RUN.
- Reset (async, any state): state=IDLE; load_ready=0, load_done=0, load_ovf=0, load_count=0, fetch_ready=0, fetch_valid=0, fetch_data=0, fetch_err=0. Array contents are not reset and are undefined after reset.
- IDLE: fetch_ready=0 and fetch_req is ignored. load_start -> LOAD.
- LOAD entry (cycle after load_start):
  - write pointer=0, load_count=0, load_ovf cleared, load_ready=1.
  - load_start while in LOAD is ignored.
- Transfer occurs when load_valid && load_ready:
  - mem[ptr] <= load_data; ptr and load_count increment.
  - If load_last: -> RUN, load_done pulses next cycle, load_ready drops next cycle.
  - Else if ptr == DEPTH-1: -> RUN, load_ovf=1, load_done pulses.
  - load_last on the word at DEPTH-1 is a normal completion with load_ovf=0.
- RUN:
  - fetch_ready=1 combinationally; load_ready=0.
  - Accept on fetch_req && fetch_ready. The next cycle gives fetch_valid=1 with:
    - fetch_data=mem[fetch_addr[$clog2(DEPTH)-1:0]] and fetch_err=0 if fetch_addr < DEPTH.
    - Otherwise fetch_data=0 and fetch_err=1.
  - fetch_valid=0 in any cycle following a non-accept. fetch_data holds its last value while fetch_valid=0.
  - Back-to-back requests give one fetch_valid per cycle, fully pipelined with no bubbles.
  - load_start in RUN -> LOAD. A fetch accepted in that same cycle still completes; fetch_valid is asserted next cycle with the pre-load data.
- Read-during-write cannot occur: fetch and load are never both enabled.
- Reset during LOAD: the partially written array is retained but undefined. IDLE requires a new load_start.
- load_count saturates at DEPTH; it does not wrap.

Test Plan:
- DEPTH=256, load A9 00 01 01 4C 02 00 with load_last on the 7th word -> load_done pulses once, load_count=7, load_ovf=0. Fetches of addr 0..6 back-to-back give fetch_data A9,00,01,01,4C,02,00 on 7 consecutive cycles, each 1 cycle after its request.
- After the load, fetch 0x0100 -> fetch_valid=1, fetch_err=1, fetch_data=00. Fetch 0x0004 next cycle -> 4C, fetch_err=0.
- DEPTH=16, stream 20 words 0x10..0x23 with no load_last -> load_ready drops after the 16th transfer, load_ovf=1, load_count=16. Fetch addr 15 -> 0x1F. Words 0x20..0x23 are not written.
- After reset, assert fetch_req for 5 cycles in IDLE -> fetch_ready=0 and fetch_valid=0 throughout.
- In RUN, assert fetch_req addr 2 and load_start in the same cycle -> next cycle fetch_valid=1, data=01, state LOAD, load_ready=1, fetch_ready=0.
- Drop rst_n after 3 load transfers -> all outputs return to reset values immediately. After a new load of 2 words, load_count=2 and fetch addr 1 returns the new word.
